// File: rtl/riscv_pkg.sv
// Shared definitions for the RV32I control path (multicycle and single-cycle
// decoders): FSM state enum, opcode constants, ALUOP / PCSRC / AUIPCLUI codes.
package riscv_pkg;

    localparam int TAM_INS_DEF      = 7;
    localparam int TAM_ALUOP_DEF    = 3;
    localparam int TAM_AUIPCLUI_DEF = 2;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [2:0] ALUOP_R     = 3'b000;
    localparam logic [2:0] ALUOP_I     = 3'b001;
    localparam logic [2:0] ALUOP_LW    = 3'b010;
    localparam logic [2:0] ALUOP_SW    = 3'b011;
    localparam logic [2:0] ALUOP_B     = 3'b100;
    localparam logic [2:0] ALUOP_LUI   = 3'b101;
    localparam logic [2:0] ALUOP_AUIPC = 3'b110;
    localparam logic [2:0] ALUOP_JUMP  = 3'b111;

    localparam logic [1:0] PCSRC_PC4 = 2'b00;
    localparam logic [1:0] PCSRC_IMM = 2'b01;
    localparam logic [1:0] PCSRC_ALU = 2'b10;

    localparam logic [1:0] AUIPCLUI_AUIPC = 2'b01;
    localparam logic [1:0] AUIPCLUI_NONE  = 2'b10;

endpackage

// File: rtl/multicycle_control_if.sv
// Bundle between the multicycle control unit and its datapath / memories.
// slave  : the control unit (consumes opcode and memory status, drives controls)
// master : the datapath side / testbench
// Handshake: imemreq is held high until the cycle imem_ready=1 is seen, and
// memread/memwrite are held high until the cycle dmem_ready=1 is seen; the
// transfer completes in that cycle and ready is ignored at all other times.
// retired_preset/retired_preset_value overwrite the retired counter (debug).
// state exposes the FSM state for observation.
interface multicycle_control_if #(
    parameter int TAM_INS      = 7,
    parameter int TAM_ALUOP    = 3,
    parameter int TAM_AUIPCLUI = 2
);
    logic [TAM_INS-1:0]      opcode;
    logic                    imem_ready;
    logic                    dmem_ready;
    logic                    br_taken;
    logic                    retired_preset;
    logic [31:0]             retired_preset_value;

    logic                    imemreq;
    logic                    irwrite;
    logic                    pcwrite;
    logic [1:0]              pcsrc;
    logic                    branch;
    logic                    memread;
    logic                    memtoreg;
    logic                    memwrite;
    logic                    alusrc;
    logic                    regwrite;
    logic [TAM_ALUOP-1:0]    aluop;
    logic [TAM_AUIPCLUI-1:0] auipclui;
    logic                    illegal;
    logic [31:0]             retired;
    riscv_pkg::state_t       state;

    modport master (
        output opcode, imem_ready, dmem_ready, br_taken, retired_preset, retired_preset_value,
        input  imemreq, irwrite, pcwrite, pcsrc, branch, memread, memtoreg, memwrite,
               alusrc, regwrite, aluop, auipclui, illegal, retired, state
    );

    modport slave (
        input  opcode, imem_ready, dmem_ready, br_taken, retired_preset, retired_preset_value,
        output imemreq, irwrite, pcwrite, pcsrc, branch, memread, memtoreg, memwrite,
               alusrc, regwrite, aluop, auipclui, illegal, retired, state
    );
endinterface

// File: rtl/opcode_decode.sv
// Combinational opcode -> ALUOP / ALUSRC / AUIPCLUI mapping, shared encoding
// with the single-cycle decoder. legal=0 flags an unsupported opcode; its
// other outputs are then the neutral values (000, 0, 10).
module opcode_decode import riscv_pkg::*; #(
    parameter int TAM_INS      = TAM_INS_DEF,
    parameter int TAM_ALUOP    = TAM_ALUOP_DEF,
    parameter int TAM_AUIPCLUI = TAM_AUIPCLUI_DEF
) (
    input  logic [TAM_INS-1:0]      opcode,
    output logic                    legal,
    output logic [TAM_ALUOP-1:0]    aluop,
    output logic                    alusrc,
    output logic [TAM_AUIPCLUI-1:0] auipclui
);
    always_comb begin
        legal    = 1'b1;
        aluop    = '0;
        alusrc   = 1'b1;
        auipclui = TAM_AUIPCLUI'(AUIPCLUI_NONE);
        case (opcode)
            TAM_INS'(OP_R):      begin aluop = TAM_ALUOP'(ALUOP_R); alusrc = 1'b0; end
            TAM_INS'(OP_I):      aluop = TAM_ALUOP'(ALUOP_I);
            TAM_INS'(OP_LOAD):   aluop = TAM_ALUOP'(ALUOP_LW);
            TAM_INS'(OP_STORE):  aluop = TAM_ALUOP'(ALUOP_SW);
            TAM_INS'(OP_BRANCH): begin aluop = TAM_ALUOP'(ALUOP_B); alusrc = 1'b0; end
            TAM_INS'(OP_LUI):    aluop = TAM_ALUOP'(ALUOP_LUI);
            TAM_INS'(OP_AUIPC):  begin
                aluop    = TAM_ALUOP'(ALUOP_AUIPC);
                auipclui = TAM_AUIPCLUI'(AUIPCLUI_AUIPC);
            end
            TAM_INS'(OP_JAL),
            TAM_INS'(OP_JALR):   aluop = TAM_ALUOP'(ALUOP_JUMP);
            default: begin
                legal  = 1'b0;
                alusrc = 1'b0;
            end
        endcase
    end
endmodule

// File: rtl/multicycle_control.sv
// Multicycle RV32I control FSM: FETCH -> DECODE -> EXEC -> (MEM) -> (WB).
// Ports: clk, rst_n (async, active low), bus (multicycle_control_if.slave)
// carrying opcode/ready/branch inputs, datapath controls, illegal pulse,
// retired-instruction counter and the FSM state.
module multicycle_control import riscv_pkg::*; #(
    parameter int TAM_INS      = TAM_INS_DEF,
    parameter int TAM_ALUOP    = TAM_ALUOP_DEF,
    parameter int TAM_AUIPCLUI = TAM_AUIPCLUI_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    multicycle_control_if.slave   bus
);
    state_t                  state_q, state_d;
    logic [TAM_INS-1:0]      op_q;
    logic [31:0]             retired_q;
    logic                    retire;

    logic [TAM_INS-1:0]      dec_op;
    logic                    dec_legal;
    logic [TAM_ALUOP-1:0]    dec_aluop;
    logic                    dec_alusrc;
    logic [TAM_AUIPCLUI-1:0] dec_auipclui;

    logic is_load, is_store, is_branch, is_jal, is_jalr;

    // In DECODE the opcode is not latched yet, so legality is judged on the
    // live input; every later state works from the latched copy.
    assign dec_op = (state_q == ST_DECODE) ? bus.opcode : op_q;

    opcode_decode #(
        .TAM_INS(TAM_INS), .TAM_ALUOP(TAM_ALUOP), .TAM_AUIPCLUI(TAM_AUIPCLUI)
    ) u_decode (
        .opcode(dec_op), .legal(dec_legal), .aluop(dec_aluop),
        .alusrc(dec_alusrc), .auipclui(dec_auipclui)
    );

    assign is_load   = (op_q == TAM_INS'(OP_LOAD));
    assign is_store  = (op_q == TAM_INS'(OP_STORE));
    assign is_branch = (op_q == TAM_INS'(OP_BRANCH));
    assign is_jal    = (op_q == TAM_INS'(OP_JAL));
    assign is_jalr   = (op_q == TAM_INS'(OP_JALR));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_FETCH;
            op_q      <= '0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_DECODE) op_q <= bus.opcode;
            if (bus.retired_preset)   retired_q <= bus.retired_preset_value;
            else if (retire)          retired_q <= retired_q + 32'd1;
        end
    end

    always_comb begin
        state_d      = state_q;
        retire       = 1'b0;
        bus.imemreq  = 1'b0;
        bus.irwrite  = 1'b0;
        bus.pcwrite  = 1'b0;
        bus.pcsrc    = PCSRC_PC4;
        bus.branch   = 1'b0;
        bus.memread  = 1'b0;
        bus.memtoreg = 1'b0;
        bus.memwrite = 1'b0;
        bus.alusrc   = 1'b0;
        bus.regwrite = 1'b0;
        bus.aluop    = '0;
        bus.auipclui = TAM_AUIPCLUI'(AUIPCLUI_NONE);
        bus.illegal  = 1'b0;
        // Outputs are gated by rst_n so they drop the instant reset asserts,
        // not at the next edge.
        if (rst_n) begin
            // ALU controls stay valid from EXEC to the end of the instruction:
            // MEM needs the address held, WB needs the JALR target.
            if (state_q == ST_EXEC || state_q == ST_MEM || state_q == ST_WB) begin
                bus.aluop    = dec_aluop;
                bus.alusrc   = dec_alusrc;
                bus.auipclui = dec_auipclui;
            end
            case (state_q)
                ST_FETCH: begin
                    bus.imemreq = 1'b1;
                    if (bus.imem_ready) begin
                        bus.irwrite = 1'b1;
                        state_d     = ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    if (dec_legal) begin
                        state_d = ST_EXEC;
                    end else begin
                        bus.illegal = 1'b1;
                        bus.pcwrite = 1'b1;
                        state_d     = ST_FETCH;
                    end
                end
                ST_EXEC: begin
                    if (is_load || is_store) begin
                        state_d = ST_MEM;
                    end else if (is_branch) begin
                        bus.branch  = 1'b1;
                        bus.pcwrite = 1'b1;
                        bus.pcsrc   = bus.br_taken ? PCSRC_IMM : PCSRC_PC4;
                        retire      = 1'b1;
                        state_d     = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end
                ST_MEM: begin
                    bus.memread  = is_load;
                    bus.memwrite = is_store;
                    if (bus.dmem_ready) begin
                        if (is_load) begin
                            state_d = ST_WB;
                        end else begin
                            bus.pcwrite = 1'b1;
                            retire      = 1'b1;
                            state_d     = ST_FETCH;
                        end
                    end
                end
                ST_WB: begin
                    bus.regwrite = 1'b1;
                    bus.pcwrite  = 1'b1;
                    bus.memtoreg = is_load;
                    bus.pcsrc    = is_jal ? PCSRC_IMM : (is_jalr ? PCSRC_ALU : PCSRC_PC4);
                    retire       = 1'b1;
                    state_d      = ST_FETCH;
                end
                default: state_d = ST_FETCH;
            endcase
        end
    end

    assign bus.retired = retired_q;
    assign bus.state   = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: a per-instruction trace model
// builds the expected control vector for every cycle, a compare process checks
// each one at the falling edge, and literal expectations pin cycle counts and
// the retired counter.
module tb_multicycle_control;
    import riscv_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    multicycle_control_if #(.TAM_INS(7), .TAM_ALUOP(3), .TAM_AUIPCLUI(2)) bus ();

    multicycle_control #(.TAM_INS(7), .TAM_ALUOP(3), .TAM_AUIPCLUI(2)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    typedef struct packed {
        logic        imemreq;
        logic        irwrite;
        logic        pcwrite;
        logic [1:0]  pcsrc;
        logic        branch;
        logic        memread;
        logic        memtoreg;
        logic        memwrite;
        logic        alusrc;
        logic        regwrite;
        logic [2:0]  aluop;
        logic [1:0]  auipclui;
        logic        illegal;
        logic [31:0] retired;
    } ctl_t;
    localparam int W = $bits(ctl_t);

    logic [W-1:0] exp_q[$];
    string        tag_q[$];
    int           checks = 0;
    int           errors = 0;
    logic [31:0]  m_retired = '0;
    int           memread_cycles = 0;
    int           regwrite_cycles = 0;

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got %h expected %h", name, $time, got, exp);
        end
    endtask

    function automatic ctl_t dut_vec();
        ctl_t v;
        v.imemreq  = bus.imemreq;   v.irwrite  = bus.irwrite;
        v.pcwrite  = bus.pcwrite;   v.pcsrc    = bus.pcsrc;
        v.branch   = bus.branch;    v.memread  = bus.memread;
        v.memtoreg = bus.memtoreg;  v.memwrite = bus.memwrite;
        v.alusrc   = bus.alusrc;    v.regwrite = bus.regwrite;
        v.aluop    = bus.aluop;     v.auipclui = bus.auipclui;
        v.illegal  = bus.illegal;   v.retired  = bus.retired;
        return v;
    endfunction

    always @(negedge clk) begin
        if (bus.memread === 1'b1)  memread_cycles++;
        if (bus.regwrite === 1'b1) regwrite_cycles++;
        if (exp_q.size() > 0) begin
            ctl_t  e;
            string t;
            e = ctl_t'(exp_q.pop_front());
            t = tag_q.pop_front();
            check(t, 64'(dut_vec()), 64'(e));
        end
    end

    // ---------------- model ----------------
    function automatic ctl_t idle_vec();
        ctl_t v = '0;
        v.auipclui = 2'b10;
        v.retired  = m_retired;
        return v;
    endfunction

    // Instruction class table: {legal, aluop, alusrc, auipclui}
    function automatic logic [6:0] ref_fields(input logic [6:0] op);
        case (op)
            7'b0110011: return {1'b1, 3'b000, 1'b0, 2'b10};
            7'b0010011: return {1'b1, 3'b001, 1'b1, 2'b10};
            7'b0000011: return {1'b1, 3'b010, 1'b1, 2'b10};
            7'b0100011: return {1'b1, 3'b011, 1'b1, 2'b10};
            7'b1100011: return {1'b1, 3'b100, 1'b0, 2'b10};
            7'b0110111: return {1'b1, 3'b101, 1'b1, 2'b10};
            7'b0010111: return {1'b1, 3'b110, 1'b1, 2'b01};
            7'b1101111: return {1'b1, 3'b111, 1'b1, 2'b10};
            7'b1100111: return {1'b1, 3'b111, 1'b1, 2'b10};
            default:    return {1'b0, 3'b000, 1'b0, 2'b10};
        endcase
    endfunction

    // ---------------- driver ----------------
    task automatic step(input string tag, input ctl_t e);
        exp_q.push_back(W'(e));
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
    endtask

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    // Runs one instruction from FETCH. rst_at >= 0 asserts reset at that MEM
    // cycle index instead of completing. ncyc = cycles the instruction took.
    task automatic run_instr(input logic [6:0] op, input int imem_wait, input int dmem_wait,
                             input logic taken, input int rst_at, output int ncyc);
        logic [6:0] f;
        logic is_ld, is_st, is_br;
        ctl_t v, a;
        f     = ref_fields(op);
        is_ld = (op == 7'b0000011);
        is_st = (op == 7'b0100011);
        is_br = (op == 7'b1100011);
        ncyc  = 0;
        for (int i = 0; i < imem_wait; i++) begin
            bus.imem_ready = 1'b0; bus.dmem_ready = rnd();
            v = idle_vec(); v.imemreq = 1'b1;
            step("fetch_wait", v); ncyc++;
        end
        bus.imem_ready = 1'b1; bus.dmem_ready = rnd();
        v = idle_vec(); v.imemreq = 1'b1; v.irwrite = 1'b1;
        step("fetch", v); ncyc++;

        bus.opcode = op; bus.imem_ready = rnd(); bus.dmem_ready = rnd();
        v = idle_vec();
        if (!f[6]) begin
            v.illegal = 1'b1; v.pcwrite = 1'b1;
            step("decode_illegal", v); ncyc++;
            return;
        end
        step("decode", v); ncyc++;

        a = idle_vec(); a.aluop = f[5:3]; a.alusrc = f[2]; a.auipclui = f[1:0];
        bus.br_taken = is_br ? taken : rnd(); bus.imem_ready = rnd(); bus.dmem_ready = rnd();
        v = a;
        if (is_br) begin
            v.branch = 1'b1; v.pcwrite = 1'b1; v.pcsrc = taken ? 2'b01 : 2'b00;
            step("exec_branch", v); ncyc++; m_retired++;
            return;
        end
        step("exec", v); ncyc++;

        if (is_ld || is_st) begin
            for (int i = 0; i <= dmem_wait; i++) begin
                if (i == rst_at) begin
                    rst_n = 1'b0;
                    #1;
                    check("rst_memwrite", 64'(bus.memwrite), 64'(0));
                    check("rst_retired", 64'(bus.retired), 64'(0));
                    check("rst_state", 64'(bus.state), 64'(ST_FETCH));
                    m_retired = '0;
                    step("in_reset", idle_vec());
                    step("in_reset", idle_vec());
                    rst_n = 1'b1;
                    return;
                end
                bus.dmem_ready = (i == dmem_wait); bus.imem_ready = rnd();
                v = a; v.memread = is_ld; v.memwrite = is_st;
                if (i == dmem_wait && is_st) begin
                    v.pcwrite = 1'b1;
                    step("mem_store_done", v); ncyc++; m_retired++;
                    return;
                end
                step((i == dmem_wait) ? "mem_done" : "mem_wait", v); ncyc++;
            end
        end

        bus.imem_ready = rnd(); bus.dmem_ready = rnd();
        v = a; v.regwrite = 1'b1; v.pcwrite = 1'b1; v.memtoreg = is_ld;
        v.pcsrc = (op == 7'b1101111) ? 2'b01 : ((op == 7'b1100111) ? 2'b10 : 2'b00);
        step("wb", v); ncyc++; m_retired++;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int n, mr0, rw0;
        bus.opcode = '0; bus.imem_ready = 1'b1; bus.dmem_ready = 1'b1; bus.br_taken = 1'b0;
        bus.retired_preset = 1'b0; bus.retired_preset_value = '0;

        @(posedge clk); #1;
        check("reset_imemreq", 64'(bus.imemreq), 64'(0));
        check("reset_retired", 64'(bus.retired), 64'(0));
        step("in_reset", idle_vec());
        step("in_reset", idle_vec());
        rst_n = 1'b1;

        run_instr(7'b0110011, 0, 0, 1'b0, -1, n);           // ADD
        check("add_cycles", 64'(n), 64'(4));
        check("add_retired", 64'(bus.retired), 64'(1));

        mr0 = memread_cycles;
        run_instr(7'b0000011, 0, 3, 1'b0, -1, n);           // LW, dmem 3 late
        check("lw_cycles", 64'(n), 64'(8));
        check("lw_memread_cycles", 64'(memread_cycles - mr0), 64'(4));

        rw0 = regwrite_cycles;
        run_instr(7'b1100011, 0, 0, 1'b1, -1, n);           // BEQ taken
        check("beq_cycles", 64'(n), 64'(3));
        run_instr(7'b1100011, 1, 0, 1'b0, -1, n);           // BNE not taken
        check("bne_cycles", 64'(n), 64'(4));
        check("branch_regwrite", 64'(regwrite_cycles - rw0), 64'(0));

        run_instr(7'b1100111, 0, 0, 1'b0, -1, n);           // JALR
        check("jalr_cycles", 64'(n), 64'(4));
        run_instr(7'b0010111, 2, 0, 1'b0, -1, n);           // AUIPC
        run_instr(7'b1101111, 0, 0, 1'b0, -1, n);           // JAL
        run_instr(7'b0110111, 0, 0, 1'b0, -1, n);           // LUI
        run_instr(7'b0010011, 0, 0, 1'b0, -1, n);           // ADDI
        rw0 = regwrite_cycles;
        run_instr(7'b0100011, 1, 0, 1'b0, -1, n);           // SW
        check("sw_cycles", 64'(n), 64'(5));
        check("sw_regwrite", 64'(regwrite_cycles - rw0), 64'(0));
        check("retired_10", 64'(bus.retired), 64'(10));

        run_instr(7'b1111111, 0, 0, 1'b0, -1, n);           // illegal
        check("illegal_cycles", 64'(n), 64'(2));
        check("illegal_retired", 64'(bus.retired), 64'(10));
        check("illegal_next_fetch", 64'(bus.state), 64'(ST_FETCH));

        bus.imem_ready = 1'b0; bus.retired_preset = 1'b1; bus.retired_preset_value = 32'hFFFF_FFFE;
        begin
            ctl_t v;
            v = idle_vec(); v.imemreq = 1'b1;
            step("preset", v);
        end
        bus.retired_preset = 1'b0;
        m_retired = 32'hFFFF_FFFE;
        run_instr(7'b0110011, 0, 0, 1'b0, -1, n);
        check("retired_max", 64'(bus.retired), 64'(32'hFFFF_FFFF));
        run_instr(7'b0110011, 0, 0, 1'b0, -1, n);
        check("retired_wrap", 64'(bus.retired), 64'(0));

        run_instr(7'b0110011, 0, 0, 1'b0, -1, n);           // retired = 1 before abort
        run_instr(7'b0100011, 0, 5, 1'b0, 2, n);            // SW, reset mid-MEM
        run_instr(7'b0110011, 0, 0, 1'b0, -1, n);
        check("after_reset_retired", 64'(bus.retired), 64'(1));

        @(posedge clk); #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
